// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer: FSM states,
// error codes and image geometry.
package cnn_pkg;

    localparam int CNN_IMG_W     = 28;
    localparam int CNN_IMG_H     = 28;
    localparam int CNN_IMG_PIX   = CNN_IMG_W * CNN_IMG_H;
    localparam int CNN_DATA_BITS = 8;
    localparam int CNN_RES_COUNT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4,
        ST_FLUSH = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;

    // Channels must report together; any partial pattern is a fault.
    function automatic logic res_mismatch(input logic [2:0] v);
        return (v != 3'b000) && (v != 3'b111);
    endfunction

endpackage

// File: rtl/cnn_watchdog.sv
// Loadable down-counter; expire fires when enabled at zero.
module cnn_watchdog #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load, load beats decrement; stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en & ~load & ~clr & (cnt_q == {W{1'b0}});

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame controller for the two-layer CNN: streams one image in, counts
// layer-2 pooled results, and flushes the pipeline on timeout or mismatch.
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_W          = CNN_IMG_W,
    parameter int IMG_H          = CNN_IMG_H,
    parameter int DATA_BITS      = CNN_DATA_BITS,
    parameter int RES_COUNT      = CNN_RES_COUNT,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear_err,
    input  logic                 s_valid,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 s_ready,
    output logic                 cnn_in_val,
    output logic [DATA_BITS-1:0] cnn_data_in,
    output logic                 cnn_rst_n,
    input  logic [2:0]           res_val,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [9:0]           pix_cnt,
    output logic [4:0]           res_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [9:0]      LAST_PIX   = 10'(IMG_W * IMG_H - 1);
    localparam logic [4:0]      RES_MAX    = 5'(RES_COUNT);
    localparam logic [WD_W-1:0] WD_LOAD    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [9:0]             pix_cnt_q, pix_cnt_d;
    logic [4:0]             res_cnt_q, res_cnt_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [FC_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic [DATA_BITS-1:0]   cnn_data_q, cnn_data_d;
    logic                   cnn_in_val_q, cnn_in_val_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_q, err_d;

    logic beat_s, res_hit_s, res_bad_s;
    logic wd_load_s, wd_en_s, wd_clr_s, wd_expire_s;

    assign beat_s    = s_valid & s_ready_q;
    assign res_hit_s = (res_val == 3'b111);
    assign res_bad_s = res_mismatch(res_val);
    assign wd_clr_s  = (state_q == ST_FLUSH);

    cnn_watchdog #(.W(WD_W)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr_s),
        .load     (wd_load_s),
        .load_val (WD_LOAD),
        .en       (wd_en_s),
        .expire   (wd_expire_s)
    );

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        res_cnt_d   = res_cnt_q;
        err_code_d  = err_code_q;
        flush_cnt_d = flush_cnt_q;
        cnn_data_d  = cnn_data_q;
        wd_load_s   = 1'b0;
        wd_en_s     = 1'b0;

        if (beat_s) begin
            cnn_data_d = s_data;
            pix_cnt_d  = pix_cnt_q + 10'd1;
        end else begin
            cnn_data_d = cnn_data_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FEED;
                    pix_cnt_d = 10'd0;
                    res_cnt_d = 5'd0;
                    wd_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (res_bad_s) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_MISMATCH;
                end else begin
                    if (res_hit_s) begin
                        wd_load_s = 1'b1;
                        res_cnt_d = (res_cnt_q < RES_MAX) ? res_cnt_q + 5'd1 : res_cnt_q;
                    end else begin
                        wd_load_s = 1'b0;
                    end
                    if (beat_s && (pix_cnt_q == LAST_PIX)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_DRAIN: begin
                // Mismatch outranks completion, completion outranks timeout.
                if (res_bad_s) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_MISMATCH;
                end else begin
                    if (res_hit_s) begin
                        wd_load_s = 1'b1;
                        res_cnt_d = (res_cnt_q < RES_MAX) ? res_cnt_q + 5'd1 : res_cnt_q;
                    end else begin
                        wd_en_s = 1'b1;
                    end
                    if (res_cnt_d >= RES_MAX) begin
                        state_d = ST_DONE;
                    end else if (wd_expire_s) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_TIMEOUT;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (clear_err) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = {FC_W{1'b0}};
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d    = ST_IDLE;
                    err_code_d = ERR_NONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + {{(FC_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d    = (state_d == ST_FEED);
        busy_d       = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        frame_done_d = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
        cnn_in_val_d = beat_s && busy_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= 10'd0;
            res_cnt_q    <= 5'd0;
            err_code_q   <= ERR_NONE;
            flush_cnt_q  <= {FC_W{1'b0}};
            cnn_data_q   <= {DATA_BITS{1'b0}};
            cnn_in_val_q <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            res_cnt_q    <= res_cnt_d;
            err_code_q   <= err_code_d;
            flush_cnt_q  <= flush_cnt_d;
            cnn_data_q   <= cnn_data_d;
            cnn_in_val_q <= cnn_in_val_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign cnn_rst_n   = ~rst & (state_q != ST_FLUSH);
    assign s_ready     = s_ready_q;
    assign cnn_in_val  = cnn_in_val_q;
    assign cnn_data_in = cnn_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign pix_cnt     = pix_cnt_q;
    assign res_cnt     = res_cnt_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: directed vector table, frame
// scenarios and a transaction-level reference model checked every cycle.
module tb_cnn_frame_sequencer;

    localparam int NPIX    = 784;
    localparam int NRES    = 16;
    localparam int TIMEOUT = 4096;
    localparam int P_IDLE = 0, P_FEED = 1, P_DRAIN = 2, P_DONE = 3, P_ERR = 4, P_FLUSH = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, clear_err = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic [2:0] res_val = 3'b000;
    logic       s_ready, cnn_in_val, cnn_rst_n, busy, frame_done, err;
    logic [7:0] cnn_data_in;
    logic [1:0] err_code;
    logic [9:0] pix_cnt;
    logic [4:0] res_cnt;

    cnn_frame_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .clear_err(clear_err),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cnn_in_val(cnn_in_val), .cnn_data_in(cnn_data_in), .cnn_rst_n(cnn_rst_n),
        .res_val(res_val), .busy(busy), .frame_done(frame_done), .err(err),
        .err_code(err_code), .pix_cnt(pix_cnt), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    // reference model state
    int m_ph, m_pix, m_res, m_idle, m_code, m_fl;
    int m_data;
    bit m_val;
    // observation counters
    int cycle_n = 0, done_seen = 0, val_seen = 0, flush_low = 0, err_rise = -1, t10 = -1;
    bit err_prev = 1'b0;

    typedef struct {
        logic st, cl, v; logic [7:0] d; logic [2:0] r;
        logic e_rdy, e_busy, e_val; logic [7:0] e_data; logic [9:0] e_pix; logic [4:0] e_res;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_n);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_pix = 0; m_res = 0; m_idle = 0; m_code = 0; m_fl = 0;
        m_data = 0; m_val = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit cl, input bit v, input int d, input int r);
        m_val = 1'b0;
        case (m_ph)
            P_IDLE: if (st) begin m_ph = P_FEED; m_pix = 0; m_res = 0; m_idle = 0; end
            P_FEED: begin
                if (v) begin m_pix++; m_data = d; m_val = 1'b1; end
                if (r == 7) begin
                    if (m_res < NRES) m_res++;
                    m_idle = 0;
                end else if (r != 0) begin
                    m_ph = P_ERR; m_code = 2; m_val = 1'b0;
                end
                if (m_ph == P_FEED && m_pix == NPIX) m_ph = P_DRAIN;
            end
            P_DRAIN: begin
                if (r != 0 && r != 7) begin
                    m_ph = P_ERR; m_code = 2;
                end else begin
                    if (r == 7) begin
                        if (m_res < NRES) m_res++;
                        m_idle = 0;
                    end else m_idle++;
                    if (m_res >= NRES) m_ph = P_DONE;
                    else if (m_idle >= TIMEOUT) begin m_ph = P_ERR; m_code = 1; end
                end
            end
            P_DONE: m_ph = P_IDLE;
            P_ERR: if (cl) begin m_ph = P_FLUSH; m_fl = 0; end
            P_FLUSH: begin
                m_fl++;
                if (m_fl >= 2) begin m_ph = P_IDLE; m_code = 0; end
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        chk("s_ready", s_ready, m_ph == P_FEED);
        chk("busy", busy, (m_ph == P_FEED) || (m_ph == P_DRAIN));
        chk("frame_done", frame_done, m_ph == P_DONE);
        chk("err", err, m_ph == P_ERR);
        chk("err_code", err_code, m_code);
        chk("cnn_rst_n", cnn_rst_n, m_ph != P_FLUSH);
        chk("cnn_in_val", cnn_in_val, m_val);
        chk("cnn_data_in", cnn_data_in, m_data);
        chk("pix_cnt", pix_cnt, m_pix);
        chk("res_cnt", res_cnt, m_res);
    endtask

    // One clock: drive inputs, advance past the edge, then model and compare.
    task automatic cyc(input bit st, input bit cl, input bit v, input logic [7:0] d, input logic [2:0] r);
        start = st; clear_err = cl; s_valid = v; s_data = d; res_val = r;
        @(posedge clk); #1;
        cycle_n++;
        model_step(st, cl, v, int'(d), int'(r));
        check_outputs();
        done_seen += int'(frame_done);
        val_seen  += int'(cnn_in_val);
        flush_low += int'(!cnn_rst_n);
        if (err && !err_prev) err_rise = cycle_n;
        err_prev = err;
    endtask

    task automatic do_async_reset();
        start = 1'b0; clear_err = 1'b0; s_valid = 1'b0; res_val = 3'b000;
        #2 rst = 1'b1;
        #1;
        chk("arst_in_val", cnn_in_val, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_pix_cnt", pix_cnt, 0);
        chk("arst_cnn_rst_n", cnn_rst_n, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_cnn_rst_n", cnn_rst_n, 0);
        rst = 1'b0;
        model_reset();
        err_prev = 1'b0;
        #1;
        chk("arst_release_cnn_rst_n", cnn_rst_n, 1);
    endtask

    // Runs a frame from IDLE (or continues one in FEED) until it leaves FEED/DRAIN.
    task automatic run_frame(input int mode, input int nres, input int bad_at,
                             input logic [2:0] bad_val, input int rst_at);
        int given = 0, guard = 0, gap = 0;
        bit v, st, mark;
        logic [2:0] r;
        if (m_ph == P_IDLE) cyc(1'b1, 1'b0, 1'b0, 8'h00, 3'b000);
        while ((m_ph == P_FEED || m_ph == P_DRAIN) && guard < 12000) begin
            guard++;
            v  = (mode == 0) ? 1'b1 : ((guard % 3) != 0);
            st = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 3'b000;
            mark = 1'b0;
            if (given == bad_at && m_ph == P_DRAIN) begin
                r = bad_val;
            end else if (given < nres &&
                         (m_ph == P_DRAIN || (mode == 1 && $urandom_range(0, 99) < 1))) begin
                if (gap == 0) begin
                    r = 3'b111; given++; gap = $urandom_range(0, 6);
                    mark = (given == 10);
                end else gap--;
            end
            if (rst_at > 0 && m_ph == P_FEED && m_pix == rst_at) begin
                do_async_reset();
                return;
            end
            cyc(st, 1'b0, v, 8'($urandom), r);
            if (mark) t10 = cycle_n;
        end
        if (guard >= 12000) chk("frame_bound", 0, 1);
    endtask

    task automatic clear_sequence();
        flush_low = 0;
        cyc(1'b1, 1'b0, 1'b1, 8'h5A, 3'b111);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 3'b000);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b000);
        chk("flush_low_cycles", flush_low, 2);
        chk("after_flush_err", err, 0);
        chk("after_flush_code", err_code, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 8'h11, 3'b111, 1'b0, 1'b0, 1'b0, 8'h00, 10'd0, 5'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'b101, 1'b0, 1'b0, 1'b0, 8'h00, 10'd0, 5'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h22, 3'b000, 1'b1, 1'b1, 1'b0, 8'h00, 10'd0, 5'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h33, 3'b000, 1'b1, 1'b1, 1'b1, 8'h33, 10'd1, 5'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h44, 3'b111, 1'b1, 1'b1, 1'b0, 8'h33, 10'd1, 5'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h55, 3'b000, 1'b1, 1'b1, 1'b1, 8'h55, 10'd2, 5'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h66, 3'b111, 1'b1, 1'b1, 1'b1, 8'h66, 10'd3, 5'd2};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h77, 3'b000, 1'b1, 1'b1, 1'b0, 8'h66, 10'd3, 5'd2};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnn_rst_n", cnn_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;
        chk("rel_cnn_rst_n", cnn_rst_n, 1);

        // Directed table: IDLE ignores res_val/clear_err, then the first FEED beats.
        val_seen = 0; done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].st, vecs[i].cl, vecs[i].v, vecs[i].d, vecs[i].r);
            chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_in_val", i), cnn_in_val, vecs[i].e_val);
            chk($sformatf("vec%0d_data", i), cnn_data_in, vecs[i].e_data);
            chk($sformatf("vec%0d_pix", i), pix_cnt, vecs[i].e_pix);
            chk($sformatf("vec%0d_res", i), res_cnt, vecs[i].e_res);
        end

        // Frame 1: no backpressure, completes from the table's partial frame.
        run_frame(0, NRES - 2, -1, 3'b000, 0);
        chk("f1_done_cnt", done_seen, 1);
        chk("f1_pulses", val_seen, NPIX);
        chk("f1_pix", pix_cnt, NPIX);
        chk("f1_res", res_cnt, NRES);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 3'b000);
        chk("done_start_ignored", busy, 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b111);

        // Frame 2: s_valid gaps, random start, results also arrive during FEED.
        val_seen = 0; done_seen = 0;
        run_frame(1, NRES, -1, 3'b000, 0);
        chk("f2_done_cnt", done_seen, 1);
        chk("f2_pulses", val_seen, NPIX);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b000);

        // Timeout after 10 results.
        done_seen = 0; err_rise = -1; t10 = -1;
        run_frame(0, 10, -1, 3'b000, 0);
        chk("to_err", err, 1);
        chk("to_code", err_code, 1);
        chk("to_latency", err_rise - t10, TIMEOUT);
        chk("to_no_done", done_seen, 0);
        clear_sequence();

        // Channel mismatch during DRAIN.
        run_frame(0, NRES, 3, 3'b101, 0);
        chk("mm_code", err_code, 2);
        chk("mm_s_ready", s_ready, 0);
        clear_sequence();

        // Mismatch in place of the 16th result wins over completion.
        done_seen = 0;
        run_frame(0, NRES, 15, 3'b011, 0);
        chk("coinc_err", err, 1);
        chk("coinc_code", err_code, 2);
        chk("coinc_no_done", done_seen, 0);
        clear_sequence();

        // Async reset at pixel 400, then a normal frame.
        run_frame(0, NRES, -1, 3'b000, 400);
        chk("arst_model_idle", m_ph, P_IDLE);
        done_seen = 0; val_seen = 0;
        run_frame(0, NRES, -1, 3'b000, 0);
        chk("f3_done_cnt", done_seen, 1);
        chk("f3_pulses", val_seen, NPIX);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
